// File: rtl/fractal_sync_rx_arbiter_if.sv
// ---------------------------------------------------------------------------
// fractal_sync_rx_arbiter_if
//
// Groups the signals between the rx arbiter and its surroundings.
//   rx FIFO side : empty_i, aggr_i, id_i (per-port heads, packed), pop_o
//   output stage : valid_o, ready_i, aggr_o, id_o, src_o
//   status       : error_timeout_o (sticky stall-timeout flag)
//
// Modports:
//   slave  - the arbiter itself (consumes FIFO heads, drives the output stage)
//   master - the environment (rx FIFOs plus downstream consumer)
// ---------------------------------------------------------------------------
interface fractal_sync_rx_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int AGGR_W  = 8,
  parameter int ID_W    = 4
);

  localparam int SRC_W = $clog2(N_PORTS);

  logic [N_PORTS-1:0]        empty_i;
  logic [N_PORTS*AGGR_W-1:0] aggr_i;
  logic [N_PORTS*ID_W-1:0]   id_i;
  logic [N_PORTS-1:0]        pop_o;
  logic                      valid_o;
  logic                      ready_i;
  logic [AGGR_W-1:0]         aggr_o;
  logic [ID_W-1:0]           id_o;
  logic [SRC_W-1:0]          src_o;
  logic                      error_timeout_o;

  modport slave (
    input  empty_i, aggr_i, id_i, ready_i,
    output pop_o, valid_o, aggr_o, id_o, src_o, error_timeout_o
  );

  modport master (
    output empty_i, aggr_i, id_i, ready_i,
    input  pop_o, valid_o, aggr_o, id_o, src_o, error_timeout_o
  );

endinterface

// File: rtl/fractal_sync_rx_arbiter.sv
// ---------------------------------------------------------------------------
// fractal_sync_rx_arbiter
//
// Round-robin arbiter and pop sequencer for the N_PORTS rx request FIFOs of a
// fractal-sync node. Each cycle the stage is free (empty, or being drained),
// the first non-empty FIFO at or after the round-robin pointer is popped and
// its head is registered into a single-entry output stage, tagged with its
// source port. A sticky error flags downstream stalls of TIMEOUT cycles.
//
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous, active-high reset
//   bus    - fractal_sync_rx_arbiter_if.slave (FIFO heads/pops, output
//            valid/ready stage with aggr/id/src, error_timeout_o)
// ---------------------------------------------------------------------------
module fractal_sync_rx_arbiter #(
  parameter int N_PORTS = 4,
  parameter int AGGR_W  = 8,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  fractal_sync_rx_arbiter_if.slave     bus
);

  localparam int SRC_W = $clog2(N_PORTS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_e;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]   src_q;
  logic [AGGR_W-1:0]  aggr_q;
  logic [ID_W-1:0]    id_q;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               err_q, err_d;

  logic               valid;
  logic               load_en;
  logic               found;
  logic               grant;
  logic               stall;
  logic [SRC_W-1:0]   grant_idx;
  logic [N_PORTS-1:0] pop;

  logic [AGGR_W-1:0]  head_aggr [N_PORTS];
  logic [ID_W-1:0]    head_id   [N_PORTS];

  // Unpack the per-port head fields so the granted port can be indexed directly.
  for (genvar n = 0; n < N_PORTS; n++) begin : g_heads
    assign head_aggr[n] = bus.aggr_i[n*AGGR_W +: AGGR_W];
    assign head_id[n]   = bus.id_i[n*ID_W +: ID_W];
  end

  assign valid   = (state_q == ST_FULL);
  assign load_en = ~rst_i & (~valid | bus.ready_i);
  assign stall   = valid & ~bus.ready_i;

  // Search starts at rr_ptr and wraps modulo N_PORTS; the sum carries one
  // extra bit so the wrap also works for non-power-of-two port counts.
  always_comb begin
    logic [SRC_W:0] cand;
    cand      = '0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      cand = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(N_PORTS)) begin
        cand = cand - (SRC_W+1)'(N_PORTS);
      end
      if (!found && !bus.empty_i[cand[SRC_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[SRC_W-1:0];
      end
    end
  end

  assign grant = load_en & found;

  // One-hot pop strobe; load_en already forces it to zero during reset.
  always_comb begin
    pop = '0;
    if (grant) begin
      pop[grant_idx] = 1'b1;
    end
  end

  // Pointer moves just past the granted port, otherwise holds.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      if (grant_idx == SRC_W'(N_PORTS - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + SRC_W'(1);
      end
    end
  end

  // Output stage FSM: a grant always (re)fills it, an accept without a
  // concurrent grant empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (grant) state_d = ST_FULL;
      ST_FULL:  if (!grant && bus.ready_i) state_d = ST_EMPTY;
    endcase
  end

  // Stall counter saturates at TIMEOUT; the error latches when it gets there.
  always_comb begin
    stall_cnt_d = '0;
    if (stall) begin
      if (stall_cnt_q == CNT_W'(TIMEOUT)) begin
        stall_cnt_d = stall_cnt_q;
      end else begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
    err_d = err_q | (stall_cnt_d == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      rr_ptr_q    <= '0;
      src_q       <= '0;
      aggr_q      <= '0;
      id_q        <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
      if (grant) begin
        aggr_q <= head_aggr[grant_idx];
        id_q   <= head_id[grant_idx];
        src_q  <= grant_idx;
      end
    end
  end

  assign bus.pop_o           = pop;
  assign bus.valid_o         = valid;
  assign bus.aggr_o          = aggr_q;
  assign bus.id_o            = id_q;
  assign bus.src_o           = src_q;
  assign bus.error_timeout_o = err_q;

endmodule
